alu_share_arb: RTL and testbench

- Shares one 32-bit combinational ALU (and/or/add/sub/slt) between two requesters, e.g. an execute-stage client and a branch-compare client.
- Accepts operand/op requests over valid/ready, arbitrates round-robin, and drives the ALU from registered operands.
- Captures z/zero and returns the result to the granted requester over a second valid/ready channel.
- The ALU itself is instantiated outside this block. Only its ports are driven and sampled here.

---
 rtl/alu_share_arb_pkg.sv | 21 ++
 rtl/alu_share_arb_rr_arb2.sv | 28 ++
 rtl/alu_share_arb.sv | 171 +++++++++++++++++
 tb/tb_alu_share_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg
//   Shared definitions for the two-requester ALU sharing block.
//   - OP_* : ALU op encodings. They are forwarded to the ALU untouched and
//            are listed here so clients and models agree on the values.
//   - state_t : FSM state encoding of alu_share_arb, also exported on the
//               debug port so checkers can follow the FSM.
package alu_share_arb_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin arbiter.
//   Ports:
//     req_i[1:0] : request lines
//     last_i     : index of the requester served most recently
//     gnt_vld_o  : at least one request present
//     gnt_idx_o  : winning index (meaningful only when gnt_vld_o=1)
//   A lone request always wins; on a tie the requester that was not served
//   last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = 1'b0;
    case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Shares one external combinational ALU between two requesters.
//   Requests are accepted only in IDLE, one at a time, round-robin. The
//   accepted operands/op are registered and drive the ALU for one EXEC
//   cycle; the ALU result and zero flag are captured and returned to the
//   granted requester, which is held in RESP until it takes the result.
//
//   Handshakes: every channel is valid/ready. A transfer happens on a rising
//   clk edge where valid and ready are both 1. The sender keeps valid and
//   payload stable until that edge; ready may depend combinationally on
//   valid; valid never depends on ready.
//
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     rN_valid/rN_ready     : request channel of requester N (0/1)
//     rN_a, rN_b, rN_op     : request payload
//     rN_rsp_valid/ready    : response channel of requester N
//     rN_z, rN_zero         : response payload (shared result register)
//     alu_a, alu_b, alu_op  : registered ALU inputs
//     alu_z, alu_zero       : ALU result inputs
//     busy                  : FSM not in IDLE
//     grant                 : requester that owns the ALU
//     state_dbg             : current FSM state
//   Latency: accept at cycle N -> rsp_valid at N+2; at least 3 cycles/op.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [2:0]       r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_z,
  output logic             r0_zero,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_z,
  output logic             r1_zero,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_z,
  input  logic             alu_zero,

  output logic             busy,
  output logic             grant,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             zero_q, zero_d;

  logic             gnt_vld;
  logic             gnt_idx;
  logic             rsp_ready_sel;

  rr_arb2 u_arb (
    .req_i     ({r1_valid, r0_valid}),
    .last_i    (last_grant_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign rsp_ready_sel = grant_q ? r1_rsp_ready : r0_rsp_ready;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    z_d          = z_q;
    zero_d       = zero_q;
    r0_ready     = 1'b0;
    r1_ready     = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // ready is gated by reset so nothing is accepted while the async
        // reset is being held.
        if (gnt_vld && !reset) begin
          r0_ready = ~gnt_idx;
          r1_ready = gnt_idx;
          grant_d  = gnt_idx;
          a_d      = gnt_idx ? r1_a  : r0_a;
          b_d      = gnt_idx ? r1_b  : r0_b;
          op_d     = gnt_idx ? r1_op : r0_op;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        z_d     = alu_z;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        r0_rsp_valid = ~grant_q;
        r1_rsp_valid = grant_q;
        // Fairness history advances only once the response is taken.
        if (rsp_ready_sel) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_AND;
      z_q          <= '0;
      zero_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      z_q          <= z_d;
      zero_q       <= zero_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign r0_z      = z_q;
  assign r1_z      = z_q;
  assign r0_zero   = zero_q;
  assign r1_zero   = zero_q;
  assign busy      = (state_q != IDLE);
  assign grant     = grant_q;
  assign state_dbg = state_q;

  // The external ALU's zero flag must agree with its result.
  a_zero_consistent: assert property (
    @(posedge clk) disable iff (reset)
    (state_q == EXEC) |-> (alu_zero == (alu_z == '0))
  );

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int WIDTH = 32;
  localparam int W     = WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             r0_valid = 1'b0, r1_valid = 1'b0;
  logic             r0_ready, r1_ready;
  logic [WIDTH-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
  logic [2:0]       r0_op = 3'b0, r1_op = 3'b0;
  logic             r0_rsp_valid, r1_rsp_valid;
  logic             r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;
  logic [WIDTH-1:0] r0_z, r1_z;
  logic             r0_zero, r1_zero;
  logic [WIDTH-1:0] alu_a, alu_b, alu_z;
  logic [2:0]       alu_op;
  logic             alu_zero;
  logic             busy, grant;
  state_t           state_dbg;

  alu_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_op(r0_op), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
    .r0_z(r0_z), .r0_zero(r0_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_op(r1_op), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
    .r1_z(r1_z), .r1_zero(r1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_zero(alu_zero),
    .busy(busy), .grant(grant), .state_dbg(state_dbg)
  );

  // External ALU model
  always_comb begin
    alu_z = '0;
    case (alu_op)
      OP_AND:  alu_z = alu_a & alu_b;
      OP_OR:   alu_z = alu_a | alu_b;
      OP_ADD:  alu_z = alu_a + alu_b;
      OP_SUB:  alu_z = alu_a - alu_b;
      OP_SLT:  alu_z = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_z = '0;
    endcase
    alu_zero = (alu_z == '0);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_rsp(input logic idx, input logic zero, input logic [WIDTH-1:0] z);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_rsp: got idx=%0d z=%0h with nothing expected", idx, z);
    end else begin
      e = exp_q.pop_front();
      chk("rsp {idx,zero,z}", {idx, zero, z}, e);
    end
  endtask

  // Monitor: pops on every response handshake, checks channel invariants.
  always @(negedge clk) begin
    if (!reset) begin
      chk("ready_while_busy", (r0_ready | r1_ready) & busy, 1'b0);
      chk("both_rsp_valid", r0_rsp_valid & r1_rsp_valid, 1'b0);
      if (r0_rsp_valid && r0_rsp_ready) check_rsp(1'b0, r0_zero, r0_z);
      if (r1_rsp_valid && r1_rsp_ready) check_rsp(1'b1, r1_zero, r1_z);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Returns at a negedge where rN_ready is high.
  task automatic wait_ready(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((n == 0 && r0_ready) || (n == 1 && r1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: r%0d_ready got 0 expected 1 within 20 cycles", n);
    end
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    bit idx;

    // Reset values; r0_valid held high to show ready is gated by reset.
    r0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_dbg, IDLE);
    chk("rst_grant", grant, 1'b0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 3'b000);
    chk("rst_zero", r0_zero, 1'b1);
    chk("rst_z", r0_z, 0);
    chk("rst_ready_gated", r0_ready, 1'b0);
    chk("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 2'b00);
    @(posedge clk); #1 reset = 1'b0; r0_valid = 1'b0;

    // T1: r0 only, 5+3, latency
    @(posedge clk); #1;
    r0_a = 32'd5; r0_b = 32'd3; r0_op = OP_ADD; r0_valid = 1'b1; r0_rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'd8});
    @(negedge clk); chk("t1_ready_N", r0_ready, 1'b1);
    @(posedge clk); #1 r0_valid = 1'b0;
    @(negedge clk); chk("t1_busy_N1", busy, 1'b1); chk("t1_no_rsp_N1", r0_rsp_valid, 1'b0);
    @(negedge clk); chk("t1_rsp_valid_N2", r0_rsp_valid, 1'b1); chk("t1_z", r0_z, 32'd8);
    @(negedge clk); chk("t1_idle_N3", busy, 1'b0);

    // T2: both valid after reset; r0 sub 7-7, r1 slt -1<1
    do_reset();
    @(posedge clk); #1;
    r0_a = 32'd7; r0_b = 32'd7; r0_op = OP_SUB; r0_valid = 1'b1;
    r1_a = 32'hFFFF_FFFF; r1_b = 32'd1; r1_op = OP_SLT; r1_valid = 1'b1; r1_rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 32'd0});
    exp_q.push_back({1'b1, 1'b0, 32'd1});
    wait_ready(0, ok);
    chk("t2_r1_loses", r1_ready, 1'b0);
    @(posedge clk); #1 r0_valid = 1'b0;
    @(negedge clk); chk("t2_grant0", grant, 1'b0);
    wait_ready(1, ok);
    @(posedge clk); #1 r1_valid = 1'b0;
    @(negedge clk); chk("t2_grant1", grant, 1'b1);
    wait_drain();

    // T3: r1 or with response backpressure; r0 waiting
    r1_rsp_ready = 1'b0;
    @(posedge clk); #1;
    r1_a = 32'hF0F0_0000; r1_b = 32'h0000_0F0F; r1_op = OP_OR; r1_valid = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'hF0F0_0F0F});
    wait_ready(1, ok);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    r0_a = 32'd1; r0_b = 32'd2; r0_op = OP_ADD; r0_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'd3});
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (r1_rsp_valid) begin ok = 1'b1; break; end
    end
    chk("t3_rsp_seen", ok, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t3_hold_valid", r1_rsp_valid, 1'b1);
      chk("t3_hold_z", r1_z, 32'hF0F0_0F0F);
      chk("t3_no_accept", r0_ready, 1'b0);
    end
    @(posedge clk); #1 r1_rsp_ready = 1'b1;
    @(negedge clk); chk("t3_no_accept_hs", r0_ready, 1'b0);
    @(negedge clk); chk("t3_accept_after_hs", r0_ready, 1'b1);
    @(posedge clk); #1 r0_valid = 1'b0;
    wait_drain();

    // T4: fairness, 6 ops with both valid; op k: a=k+1, b=10 -> z=k+11
    do_reset();
    @(posedge clk); #1;
    r0_a = 32'd1; r0_b = 32'd10; r0_op = OP_ADD; r0_valid = 1'b1;
    r1_a = 32'd2; r1_b = 32'd10; r1_op = OP_ADD; r1_valid = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back({k[0], 1'b0, 32'(k + 11)});
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (r0_ready || r1_ready) begin ok = 1'b1; break; end
      end
      chk("t4_accept_seen", ok, 1'b1);
      if (!ok) break;
      idx = r1_ready;
      chk("t4_grant_seq", idx, k[0]);
      @(posedge clk); #1;
      if (!idx) begin
        if (k + 2 < 6) r0_a = 32'(k + 3); else r0_valid = 1'b0;
      end else begin
        if (k + 2 < 6) r1_a = 32'(k + 3); else r1_valid = 1'b1 & 1'b0;
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    wait_drain();

    // T5: async reset mid-EXEC drops the op
    @(posedge clk); #1;
    r0_a = 32'd9; r0_b = 32'd9; r0_op = OP_ADD; r0_valid = 1'b1;
    wait_ready(0, ok);
    @(posedge clk); #3 reset = 1'b1;
    #1;
    chk("t5_busy", busy, 1'b0);
    chk("t5_rsp_valid", r0_rsp_valid, 1'b0);
    chk("t5_ready", r0_ready, 1'b0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_b", alu_b, 0);
    chk("t5_alu_op", alu_op, 3'b000);
    chk("t5_grant", grant, 1'b0);
    chk("t5_zero", r0_zero, 1'b1);
    r0_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", {r0_rsp_valid, r1_rsp_valid, busy}, 3'b000);
    end

    // T6: tie after reset (r0 wins); and 0xFFFF0000 & 0x0000FFFF
    @(posedge clk); #1;
    r0_a = 32'hFFFF_0000; r0_b = 32'h0000_FFFF; r0_op = OP_AND; r0_valid = 1'b1;
    r1_a = 32'd2; r1_b = 32'd2; r1_op = OP_ADD; r1_valid = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 32'd0});
    exp_q.push_back({1'b1, 1'b0, 32'd4});
    wait_ready(0, ok);
    chk("t6_tie_r0_wins", r1_ready, 1'b0);
    @(posedge clk); #1 r0_valid = 1'b0;
    @(negedge clk);
    chk("t6_exec_state", state_dbg, EXEC);
    chk("t6_alu_op_exec", alu_op, 3'b000);
    chk("t6_alu_a_exec", alu_a, 32'hFFFF_0000);
    wait_ready(1, ok);
    @(posedge clk); #1 r1_valid = 1'b0;
    wait_drain();

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
